// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
// Issues one outstanding instruction-memory request at a time, presents the
// returned word in the IF/ID register, absorbs ID-stage stalls with a
// one-entry hold buffer and redirects the PC on ID-stage branch decisions.
//
// Build option: define BRANCH_DELAY_SLOT_EN to give branches a delay slot.
// Then a redirect does not flush anything; the target is held pending and is
// applied after the next delivered instruction instead of pc+4.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | imem_req high at imem_addr=pc, waiting for a grant
// WAIT  | request granted, waiting for its response (r_live: still wanted)
// HOLD  | response captured in the hold buffer while ID is stalled
//
// Killed responses: r_kill counts granted requests whose response must be
// thrown away. Memory responds in order, so the next r_kill responses are
// always the dead ones.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  branch,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        redirect
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_redirect;
    logic        r_live;
    logic [1:0]  r_kill;

    logic [31:0] w_id_pc_p4;
    logic [31:0] w_br_off;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic [31:0] w_inst;
    logic        w_redir;
    logic        w_flush;
    logic        w_rsp_live;
    logic        w_deliver;
    logic        w_kill_inc;
    logic        w_kill_dec;
    logic [1:0]  w_kill_next;

    // A branch only counts when ID holds a real instruction and is moving on.
    assign w_redir    = (branch != 2'b00) && r_if_id_valid && !stall;

    assign w_id_pc_p4 = id_pc + 32'd4;
    assign w_br_off   = {{14{id_inst[15]}}, id_inst[15:0], 2'b00};

    // Redirect target for the branch kind decided in ID.
    always_comb begin
        w_target = w_id_pc_p4;
        case (branch)
            2'b01: w_target = w_id_pc_p4 + w_br_off;
            2'b10: begin
                if (id_inst[31:26] == 6'b000010) begin
                    w_target = {w_id_pc_p4[31:28], id_inst[25:0], 2'b00};
                end else begin
                    w_target = ra;
                end
            end
            2'b11:   w_target = ra;
            default: w_target = w_id_pc_p4;
        endcase
    end

    // A response is the live one only once every dead response has drained.
    assign w_rsp_live = (r_state == S_WAIT) && imem_rvalid && (r_kill == 2'd0);
    assign w_deliver  = !w_flush && !stall && (w_rsp_live || (r_state == S_HOLD));
    assign w_inst     = (r_state == S_HOLD) ? r_buf : imem_rdata;

    // A flush turns any granted-but-unanswered live request into a dead one.
    assign w_kill_inc = w_flush &&
                        (((r_state == S_REQ) && imem_gnt) ||
                         ((r_state == S_WAIT) && r_live && !w_rsp_live));
    assign w_kill_dec = imem_rvalid && (r_kill != 2'd0) && (r_state != S_HOLD);
    assign w_kill_next = r_kill + {1'b0, w_kill_inc} - {1'b0, w_kill_dec};

`ifdef BRANCH_DELAY_SLOT_EN
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    assign w_flush   = 1'b0;
    // A redirect coinciding with delivery applies to that delivered slot.
    assign w_pc_next = w_redir      ? w_target :
                       r_pend_valid ? r_pend_target : (r_pc + 32'd4);

    // Hold the branch target until the delay-slot instruction is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_deliver) begin
            r_pend_valid  <= 1'b0;
        end else if (w_redir) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_target;
        end
    end
`else
    assign w_flush   = w_redir;
    assign w_pc_next = r_pc + 32'd4;
`endif

    // Fetch FSM together with PC, IF/ID register, hold buffer and kill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_buf         <= '0;
            r_if_id_inst  <= '0;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
            r_redirect    <= 1'b0;
            r_live        <= 1'b0;
            r_kill        <= 2'd0;
        end else begin
            r_redirect <= w_redir;
            r_kill     <= w_kill_next;

            if (w_deliver) begin
                r_if_id_inst  <= w_inst;
                r_if_id_pc    <= r_pc;
                r_if_id_valid <= 1'b1;
                r_pc          <= w_pc_next;
            end else if (!stall) begin
                // ID consumed its instruction and nothing replaces it: bubble.
                r_if_id_valid <= 1'b0;
            end

            if (w_flush) begin
                r_pc <= w_target;
            end

            case (r_state)
                S_REQ: begin
                    // A grant in a flush cycle is for the old pc; stay and
                    // request the target next cycle, the grant is counted dead.
                    if (!w_flush && imem_gnt) begin
                        r_state <= S_WAIT;
                        r_live  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_rsp_live) begin
                        if (w_flush || !stall) begin
                            r_state <= S_REQ;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end else begin
                        if (w_flush) begin
                            r_live <= 1'b0;
                        end
                        // Nothing wanted is outstanding once the dead ones drain.
                        if ((!r_live || w_flush) && (w_kill_next == 2'd0)) begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_flush || !stall) begin
                        r_buf   <= '0;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign if_id_inst  = r_if_id_inst;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign redirect    = r_redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit.
// Memory model answers every grant one cycle later with addr ^ 32'hC0DE_0000
// unless the test takes manual control of the response.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  branch;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        redirect;

    int checks;
    int errors;
    bit auto_rsp;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .branch      (branch),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .ra          (ra),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .redirect    (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = imem_req && imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp && g) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; branch = 2'b00;
        id_inst = 32'h0; id_pc = 32'h0; ra = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; auto_rsp = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Leaves IF/ID = {f(0), 0} valid, FSM in REQ at pc 4.
    task automatic prime();
        do_reset();
        tick();
        tick();
    endtask

    task automatic test_reset();
        prime();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", if_id_inst); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", imem_req); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", redirect); end
    endtask

    task automatic test_sequential();
        logic [31:0] p;
        prime();
        checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_inst !== 32'hC0DE_0000) begin
            errors++; $display("FAIL seq_first got pc %h v %b inst %h exp pc 0 v 1 inst c0de0000", if_id_pc, if_id_valid, if_id_inst); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr0 got %h exp 4", imem_addr); end
        for (int i = 1; i <= 4; i++) begin
            p = 32'(i * 4);
            tick();
            checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin
                errors++; $display("FAIL seq_bubble got v %b req %b exp v 0 req 0", if_id_valid, imem_req); end
            tick();
            checks++; if (if_id_pc !== p || if_id_valid !== 1'b1 || if_id_inst !== (p ^ 32'hC0DE_0000)) begin
                errors++; $display("FAIL seq_deliver got pc %h v %b inst %h exp pc %h v 1", if_id_pc, if_id_valid, if_id_inst, p); end
            checks++; if (imem_addr !== p + 32'h4 || imem_req !== 1'b1) begin
                errors++; $display("FAIL seq_addr got %h req %b exp %h req 1", imem_addr, imem_req, p + 32'h4); end
        end
    endtask

    task automatic test_beq();
        prime();
        branch = 2'b01; id_pc = 32'h0000_0100; id_inst = 32'h1000_FFFE;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL beq_pulse got redir %b v %b exp redir 1 v 0", redirect, if_id_valid); end
        checks++; if (imem_addr !== 32'h0000_00FC || imem_req !== 1'b1) begin
            errors++; $display("FAIL beq_target got %h req %b exp 000000fc req 1", imem_addr, imem_req); end
        tick();
        checks++; if (redirect !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL beq_after got redir %b v %b exp 0 0", redirect, if_id_valid); end
        tick();
        checks++; if (if_id_pc !== 32'h0000_00FC || if_id_inst !== 32'hC0DE_00FC || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL beq_deliver got pc %h inst %h v %b exp 000000fc c0de00fc 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

    task automatic test_jump();
        prime();
        stall = 1'b1; auto_rsp = 1'b0;
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin
            errors++; $display("FAIL j_stall_hold got v %b pc %h exp 1 0", if_id_valid, if_id_pc); end
        stall = 1'b0; branch = 2'b10; id_inst = 32'h0800_0040; id_pc = 32'h1000_0000;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1 || imem_addr !== 32'h1000_0100 || imem_req !== 1'b0) begin
            errors++; $display("FAIL j_redirect got redir %b addr %h req %b exp 1 10000100 0", redirect, imem_addr, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_0004;
        tick();
        checks++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h1000_0100) begin
            errors++; $display("FAIL j_discard got v %b pc %h req %b addr %h exp 0 0 1 10000100", if_id_valid, if_id_pc, imem_req, imem_addr); end
        auto_rsp = 1'b1;
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h1000_0100 || if_id_inst !== 32'hD0DE_0100 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL j_deliver got pc %h inst %h v %b exp 10000100 d0de0100 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

    task automatic test_stall();
        prime();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'hC0DE_0000 || if_id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold cycle %0d got pc %h inst %h v %b exp 0 c0de0000 1", i, if_id_pc, if_id_inst, if_id_valid); end
        end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL stall_pc got req %b addr %h exp 0 4", imem_req, imem_addr); end
        stall = 1'b0;
        tick();
        checks++; if (if_id_pc !== 32'h4 || if_id_inst !== 32'hC0DE_0004 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release got pc %h inst %h v %b exp 4 c0de0004 1", if_id_pc, if_id_inst, if_id_valid); end
        checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
            errors++; $display("FAIL stall_next got addr %h req %b exp 8 1", imem_addr, imem_req); end
    endtask

    task automatic test_jr_coincident();
        prime();
        stall = 1'b1;
        tick();
        stall = 1'b0; branch = 2'b10; id_inst = 32'h03E0_0008; id_pc = 32'h0; ra = 32'h0000_2000;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0) begin
            errors++; $display("FAIL jr_drop got redir %b v %b pc %h exp 1 0 0", redirect, if_id_valid, if_id_pc); end
        checks++; if (imem_addr !== 32'h0000_2000 || imem_req !== 1'b1) begin
            errors++; $display("FAIL jr_target got %h req %b exp 00002000 1", imem_addr, imem_req); end
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0000_2000 || if_id_inst !== 32'hC0DE_2000 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL jr_deliver got pc %h inst %h v %b exp 00002000 c0de2000 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

    task automatic test_jalr_hold();
        prime();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0; branch = 2'b11; id_inst = 32'h0000_0009; ra = 32'h0000_3000;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 32'h0000_3000 || imem_req !== 1'b1) begin
            errors++; $display("FAIL jalr_hold got redir %b v %b addr %h req %b exp 1 0 00003000 1", redirect, if_id_valid, imem_addr, imem_req); end
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0000_3000 || if_id_inst !== 32'hC0DE_3000 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL jalr_deliver got pc %h inst %h v %b exp 00003000 c0de3000 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

    task automatic test_branch_ignored();
        prime();
        tick();
        branch = 2'b01; id_pc = 32'h0000_0100; id_inst = 32'h1000_FFFE;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b0 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL br_ignored got redir %b pc %h v %b addr %h exp 0 4 1 8", redirect, if_id_pc, if_id_valid, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        prime();
        auto_rsp = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL late_rvalid got v %b inst %h addr %h req %b exp 0 0 0 1", if_id_valid, if_id_inst, imem_addr, imem_req); end
        imem_gnt = 1'b1; auto_rsp = 1'b1;
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'hC0DE_0000 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL rst_refetch got pc %h inst %h v %b exp 0 c0de0000 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

`ifdef BRANCH_DELAY_SLOT_EN
    task automatic test_delay_slot();
        prime();
        branch = 2'b10; id_inst = 32'h03E0_0008; id_pc = 32'h0; ra = 32'h0000_0100;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL ds_jr_pulse got %b exp 1", redirect); end
        tick();
        checks++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL ds_jr_slot got pc %h v %b addr %h exp 4 1 00000100", if_id_pc, if_id_valid, imem_addr); end
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0000_0100 || if_id_valid !== 1'b1 || imem_addr !== 32'h0000_0104) begin
            errors++; $display("FAIL ds_at_100 got pc %h v %b addr %h exp 100 1 104", if_id_pc, if_id_valid, imem_addr); end
        branch = 2'b01; id_pc = 32'h0000_0100; id_inst = 32'h1000_003F;
        tick();
        branch = 2'b00;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL ds_beq_pulse got %b exp 1", redirect); end
        tick();
        checks++; if (if_id_pc !== 32'h0000_0104 || if_id_inst !== 32'hC0DE_0104 || if_id_valid !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL ds_slot got pc %h inst %h v %b addr %h exp 104 c0de0104 1 200", if_id_pc, if_id_inst, if_id_valid, imem_addr); end
        tick();
        tick();
        checks++; if (if_id_pc !== 32'h0000_0200 || if_id_inst !== 32'hC0DE_0200 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL ds_target got pc %h inst %h v %b exp 200 c0de0200 1", if_id_pc, if_id_inst, if_id_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_ignored();
        test_reset_mid_wait();
`ifdef BRANCH_DELAY_SLOT_EN
        test_delay_slot();
`else
        test_beq();
        test_jump();
        test_jr_coincident();
        test_jalr_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
